// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of the UART receiver: FWFT read port plus sticky error flags.
// Handshake: rd_data/rd_perr/rd_ferr are valid while !empty; a word is popped on every rising edge where rd_en && !empty.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                        rd_en;
    logic                        err_clr;
    logic [DATA_BITS-1:0]        rd_data;
    logic                        rd_perr;
    logic                        rd_ferr;
    logic                        empty;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        overrun;
    logic                        break_det;

    modport slave (
        input  rd_en, err_clr,
        output rd_data, rd_perr, rd_ferr, empty, full, count, overrun, break_det
    );

    modport master (
        output rd_en, err_clr,
        input  rd_data, rd_perr, rd_ferr, empty, full, count, overrun, break_det
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority vote, parity/framing checks,
// break detection and a first-word-fall-through FIFO of {ferr, perr, data} words.
module uart_rx_fifo #(
    parameter int CLK_DIV     = 27,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BIT    = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    uart_rx_fifo_if.slave        bus,
    output logic [2:0]           dbg_state_o
);
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int M     = OVERSAMPLE / 2;

    localparam logic [SC_W-1:0]  IDX_A     = SC_W'(M - 1);
    localparam logic [SC_W-1:0]  IDX_B     = SC_W'(M);
    localparam logic [SC_W-1:0]  IDX_C     = SC_W'(M + 1);
    localparam logic [SC_W-1:0]  IDX_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) div_q <= '0;
        else             div_q <= div_q + 1'b1;
    end

    state_t               state_q;
    logic [SC_W-1:0]      sc_q, sc_next;
    logic                 smp_a_q, smp_b_q;
    logic [3:0]           bit_cnt_q;
    logic                 stop_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q, ferr_q;
    logic                 maj, at_mid, at_end, frame_done, ferr_now;

    // The third vote is the live synchronized sample taken at index M+1.
    assign maj        = (smp_a_q & smp_b_q) | (smp_a_q & rx_s_q) | (smp_b_q & rx_s_q);
    assign sc_next    = (sc_q == IDX_LAST) ? '0 : sc_q + 1'b1;
    assign at_mid     = tick && (sc_q == IDX_C);
    assign at_end     = tick && (sc_q == IDX_LAST);
    assign frame_done = at_mid && (state_q == S_STOP) && (stop_cnt_q == LAST_STOP);
    assign ferr_now   = ferr_q | ~maj;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sc_q       <= '0;
            smp_a_q    <= 1'b1;
            smp_b_q    <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (tick) begin
            sc_q <= sc_next;
            if (sc_q == IDX_A) smp_a_q <= rx_s_q;
            if (sc_q == IDX_B) smp_b_q <= rx_s_q;
            case (state_q)
                S_IDLE: begin
                    sc_q       <= rx_s_q ? SC_W'(0) : SC_W'(1);
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    perr_q     <= 1'b0;
                    ferr_q     <= 1'b0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (at_mid && maj) begin
                        state_q <= S_IDLE;
                        sc_q    <= '0;
                    end else if (at_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_mid) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_cnt_q == LAST_DATA)
                            state_q <= (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
                        else
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (at_mid)
                        perr_q <= (PARITY_TYPE == 1) ? (maj != ^shift_q) : (maj == ^shift_q);
                    if (at_end) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (at_mid) begin
                        ferr_q <= ferr_now;
                        // Leave at mid-bit so the next start edge is not missed.
                        if (stop_cnt_q == LAST_STOP) begin
                            state_q <= S_IDLE;
                            sc_q    <= '0;
                        end
                    end
                    if (at_end) stop_cnt_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    sc_q    <= '0;
                end
            endcase
        end
    end

    logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 empty, full, push, pop;
    logic                 overrun_q, break_q;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = bus.rd_en && !empty;
    assign push  = frame_done && (!full || bus.rd_en);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {ferr_now, perr_q, shift_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Set events take priority over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            if (frame_done && full && !bus.rd_en) overrun_q <= 1'b1;
            else if (bus.err_clr)                 overrun_q <= 1'b0;
            if (frame_done && ferr_now && (shift_q == '0)) break_q <= 1'b1;
            else if (bus.err_clr)                          break_q <= 1'b0;
        end
    end

    assign {bus.rd_ferr, bus.rd_perr, bus.rd_data} = mem_q[rd_ptr_q];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overrun   = overrun_q;
    assign bus.break_det = break_q;
endmodule
